// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared pipeline control types: FSM states, x0 register, stage indices
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } pipe_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - decoder/pipeline-register side bundle; PERF_CNT_EN adds counter outputs
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic       id_ecall;
  logic [4:0] ex_rd;
  logic       ex_mem_read;
  logic       ex_redirect;
  logic       mem_req;
  logic       dmem_ready;
  logic       pc_stall;
  logic       if_id_stall;
  logic       if_id_flush;
  logic       id_ex_stall;
  logic       id_ex_flush;
  logic       ex_mem_stall;
  logic       mem_wb_flush;
  logic       halted;
  logic       mem_err;
`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ecall,
    output ex_rd, ex_mem_read, ex_redirect, mem_req, dmem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    input  ex_mem_stall, mem_wb_flush, halted, mem_err
`ifdef PERF_CNT_EN
    , input cyc_cnt, stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ecall,
    input  ex_rd, ex_mem_read, ex_redirect, mem_req, dmem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
    output ex_mem_stall, mem_wb_flush, halted, mem_err
`ifdef PERF_CNT_EN
    , output cyc_cnt, stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// rtl/pipeline_hazard_ctrl_hazard_detect.sv - combinational load-use compare between EX load and ID sources
module hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_mem_read_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
  assign load_use_o = ex_mem_read_i && (ex_rd_i != REG_X0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - RV32I 5-stage stall/flush sequencer (RUN/MEM_WAIT/DRAIN/HALT)
// PERF_CNT_EN adds cycle/stall/flush performance counters.
module pipeline_hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int DRAIN_CYC   = 3,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYC);

  pipe_state_e          state_q, state_d;
  pipe_state_e          ret_q, ret_d;
  pipe_state_e          eff_state;
  logic [WAIT_W-1:0]    wait_q, wait_d, wait_inc;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 mem_err_q, mem_err_d;
  logic                 load_use;
  logic                 mem_wait;
  logic                 redirect_taken;

  hazard_detect u_hazard_detect (
    .id_rs1_i      (bus.id_rs1),
    .id_rs2_i      (bus.id_rs2),
    .id_use_rs1_i  (bus.id_use_rs1),
    .id_use_rs2_i  (bus.id_use_rs2),
    .ex_rd_i       (bus.ex_rd),
    .ex_mem_read_i (bus.ex_mem_read),
    .load_use_o    (load_use)
  );

  assign mem_wait  = bus.mem_req && !bus.dmem_ready;
  // MEM_WAIT behaves as the state it interrupted once memory releases
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
  assign wait_inc  = ((state_q == ST_MEM_WAIT) ? wait_q : '0) + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      ret_q     <= ST_RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ret_d            = ret_q;
    wait_d           = wait_q;
    drain_d          = drain_q;
    mem_err_d        = mem_err_q;
    redirect_taken   = 1'b0;
    bus.pc_stall     = 1'b0;
    bus.if_id_stall  = 1'b0;
    bus.if_id_flush  = 1'b0;
    bus.id_ex_stall  = 1'b0;
    bus.id_ex_flush  = 1'b0;
    bus.ex_mem_stall = 1'b0;
    bus.mem_wb_flush = 1'b0;
    bus.halted       = 1'b0;
    bus.mem_err      = mem_err_q;

    if (state_q == ST_HALT) begin
      bus.pc_stall     = 1'b1;
      bus.if_id_stall  = 1'b1;
      bus.id_ex_stall  = 1'b1;
      bus.ex_mem_stall = 1'b1;
      bus.if_id_flush  = 1'b1;
      bus.halted       = 1'b1;
    end else if (mem_wait) begin
      bus.pc_stall     = 1'b1;
      bus.if_id_stall  = 1'b1;
      bus.id_ex_stall  = 1'b1;
      bus.ex_mem_stall = 1'b1;
      bus.mem_wb_flush = 1'b1;
      wait_d           = wait_inc;
      if (wait_inc == WAIT_LAST) begin
        state_d   = ST_HALT;
        mem_err_d = 1'b1;
      end else begin
        state_d = ST_MEM_WAIT;
        ret_d   = eff_state;
      end
    end else begin
      wait_d = '0;
      if (eff_state == ST_DRAIN) begin
        // ID is already flushed, so redirect and load-use are moot here
        bus.pc_stall    = 1'b1;
        bus.if_id_flush = 1'b1;
        drain_d         = drain_q + 1'b1;
        state_d         = (drain_d == DRAIN_LAST) ? ST_HALT : ST_DRAIN;
      end else begin
        state_d = ST_RUN;
        if (bus.ex_redirect) begin
          bus.if_id_flush = 1'b1;
          bus.id_ex_flush = 1'b1;
          redirect_taken  = 1'b1;
        end else if (load_use) begin
          bus.pc_stall    = 1'b1;
          bus.if_id_stall = 1'b1;
          bus.id_ex_flush = 1'b1;
        end else if (bus.id_ecall) begin
          state_d = ST_DRAIN;
          drain_d = '0;
        end
      end
    end

    if (reset) begin
      bus.pc_stall     = 1'b0;
      bus.if_id_stall  = 1'b0;
      bus.if_id_flush  = 1'b1;
      bus.id_ex_stall  = 1'b0;
      bus.id_ex_flush  = 1'b1;
      bus.ex_mem_stall = 1'b0;
      bus.mem_wb_flush = 1'b0;
      bus.halted       = 1'b0;
      bus.mem_err      = 1'b0;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (state_q != ST_HALT) begin
      cyc_cnt_q <= cyc_cnt_q + 1'b1;
      if (bus.pc_stall) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect_taken) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign bus.cyc_cnt   = cyc_cnt_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed + random checks of pipeline_hazard_ctrl against a behavioural model
module tb_pipeline_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int DRAIN_CYC   = 3;

  // output vector order: pc, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush, halted
  localparam logic [7:0] O_NONE  = 8'b0000_0000;
  localparam logic [7:0] O_RESET = 8'b0010_1000;
  localparam logic [7:0] O_HALT  = 8'b1111_0101;
  localparam logic [7:0] O_MWAIT = 8'b1101_0110;
  localparam logic [7:0] O_DRAIN = 8'b1010_0000;
  localparam logic [7:0] O_REDIR = 8'b0010_1000;
  localparam logic [7:0] O_LDUSE = 8'b1100_1000;

  logic clk = 1'b0;
  logic reset;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .DRAIN_CYC   (DRAIN_CYC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: halted/err flags, remaining drain cycles, consecutive memory-wait cycles
  bit m_halted;
  bit m_err;
  int m_drain_left;
  int m_wait_run;

  task automatic idle();
    reset           = 1'b0;
    bus.id_rs1      = 5'd0;
    bus.id_rs2      = 5'd0;
    bus.id_use_rs1  = 1'b0;
    bus.id_use_rs2  = 1'b0;
    bus.id_ecall    = 1'b0;
    bus.ex_rd       = 5'd0;
    bus.ex_mem_read = 1'b0;
    bus.ex_redirect = 1'b0;
    bus.mem_req     = 1'b0;
    bus.dmem_ready  = 1'b1;
  endtask

  task automatic step(input string tag);
    logic [7:0] exp_o;
    logic [7:0] obs_o;
    bit         exp_err;
    bit         lu;
    #1;
    exp_o   = O_NONE;
    exp_err = m_err;
    lu = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
         ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    if (reset) begin
      exp_o        = O_RESET;
      exp_err      = 1'b0;
      m_halted     = 1'b0;
      m_err        = 1'b0;
      m_drain_left = 0;
      m_wait_run   = 0;
    end else if (m_halted) begin
      exp_o = O_HALT;
    end else if (bus.mem_req && !bus.dmem_ready) begin
      exp_o      = O_MWAIT;
      m_wait_run = m_wait_run + 1;
      if (m_wait_run >= MEM_TIMEOUT) begin
        m_halted = 1'b1;
        m_err    = 1'b1;
      end
    end else begin
      m_wait_run = 0;
      if (m_drain_left > 0) begin
        exp_o        = O_DRAIN;
        m_drain_left = m_drain_left - 1;
        if (m_drain_left == 0) m_halted = 1'b1;
      end else if (bus.ex_redirect) begin
        exp_o = O_REDIR;
      end else if (lu) begin
        exp_o = O_LDUSE;
      end else if (bus.id_ecall) begin
        m_drain_left = DRAIN_CYC;
      end
    end
    obs_o = {bus.pc_stall, bus.if_id_stall, bus.if_id_flush, bus.id_ex_stall,
             bus.id_ex_flush, bus.ex_mem_stall, bus.mem_wb_flush, bus.halted};
    n_checks++;
    assert (obs_o === exp_o) n_pass++;
    else $error("FAIL %s outputs observed=%b expected=%b", tag, obs_o, exp_o);
    n_checks++;
    assert (bus.mem_err === exp_err) n_pass++;
    else $error("FAIL %s mem_err observed=%b expected=%b", tag, bus.mem_err, exp_err);
    @(negedge clk);
  endtask

  task automatic reset_cycle(input string tag);
    idle();
    reset = 1'b1;
    step(tag);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    step("reset_a");
    reset_cycle("reset_b");
    step("run_idle");

    // lw x5 in EX, add x6,x5,x1 in ID
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd5;
    bus.id_use_rs1 = 1'b1; bus.id_use_rs2 = 1'b1; bus.id_rs1 = 5'd5; bus.id_rs2 = 5'd1;
    step("load_use");
    bus.ex_mem_read = 1'b0;
    step("load_use_release");
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd0; bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    step("load_use_x0");
    bus.ex_rd = 5'd7; bus.id_rs1 = 5'd3; bus.id_rs2 = 5'd7;
    step("load_use_rs2");
    bus.ex_redirect = 1'b1;
    step("redirect_over_load_use");
    idle();

    // 4 wait cycles then ready
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("mem_wait");
    bus.dmem_ready = 1'b1;
    step("mem_ready_release");
    idle();
    step("after_mem");

    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT; i++) step("mem_timeout_wait");
    idle();
    for (int i = 0; i < 3; i++) step("timeout_halted");
    n_checks++;
    assert (bus.halted === 1'b1 && bus.mem_err === 1'b1) n_pass++;
    else $error("FAIL timeout_sticky observed=%b%b expected=11", bus.halted, bus.mem_err);
    reset_cycle("reset_from_halt");

    bus.id_ecall = 1'b1;
    step("ecall");
    bus.id_ecall = 1'b0; bus.ex_redirect = 1'b1;
    for (int i = 0; i < DRAIN_CYC; i++) step("drain");
    idle();
    step("drain_halted");
    reset_cycle("reset_after_drain");

    bus.id_ecall = 1'b1; bus.ex_redirect = 1'b1;
    step("ecall_wrong_path");
    idle();
    step("ecall_wrong_path_run");

    // reset mid-DRAIN, then ecall must drain full length again
    bus.id_ecall = 1'b1;
    step("ecall2");
    idle();
    step("drain_part");
    reset_cycle("reset_mid_drain");
    bus.id_ecall = 1'b1;
    step("ecall3");
    idle();
    for (int i = 0; i < DRAIN_CYC + 1; i++) step("drain_after_reset");
    reset_cycle("reset_b2");

    // reset mid-MEM_WAIT, wait counter must restart from zero
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 10; i++) step("mem_wait_pre");
    reset_cycle("reset_mid_wait");
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < MEM_TIMEOUT - 1; i++) step("mem_wait_post");
    bus.dmem_ready = 1'b1;
    step("mem_wait_post_release");

    // mem wait during DRAIN freezes the drain count
    idle();
    bus.id_ecall = 1'b1;
    step("ecall4");
    idle();
    step("drain_1");
    bus.mem_req = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("drain_mem_wait");
    idle();
    for (int i = 0; i < DRAIN_CYC; i++) step("drain_resume");
    reset_cycle("reset_c");

    for (int i = 0; i < 1500; i++) begin
      reset           = ($urandom_range(0, 99) == 0);
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_use_rs1  = 1'($urandom_range(0, 1));
      bus.id_use_rs2  = 1'($urandom_range(0, 1));
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.ex_mem_read = 1'($urandom_range(0, 1));
      bus.ex_redirect = ($urandom_range(0, 5) == 0);
      bus.id_ecall    = ($urandom_range(0, 15) == 0);
      bus.mem_req     = ($urandom_range(0, 2) == 0);
      bus.dmem_ready  = ($urandom_range(0, 3) == 0);
      step("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
